// File: rtl/fifo_sel_drain.sv
// Locks onto the port FIFO named by the select code and drains one length-prefixed
// packet onto a registered valid/ready stream. Optional stall watchdog: FIFO_DRAIN_WDOG_EN.
`timescale 1ns/1ps
module fifo_sel_drain #(
  parameter int PORT_NUM   = 6,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic                       glb_clk,
  input  logic                       glb_areset,
  input  logic [7:0]                 fifo_sel_res_final,
  input  logic [PORT_NUM-1:0]        fifo_empty,
  input  logic [PORT_NUM*DATA_W-1:0] fifo_rdata,
  output logic [PORT_NUM-1:0]        fifo_rd_en,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic                       drain_busy,
  output logic                       pkt_done,
  output logic                       drain_err
);

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] head_data_s;
  logic              head_empty_s;
  logic [LEN_W-1:0]  hdr_len_s;
  logic              draining_s;
  logic              pop_s;
  logic              sel_valid_s;
  logic              sel_in_range_s;

`ifdef FIFO_DRAIN_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Head word and empty flag of the locked FIFO; the latched index is always in range.
  always_comb begin
    head_data_s  = '0;
    head_empty_s = 1'b1;
    for (int i = 0; i < PORT_NUM; i++) begin
      head_data_s  = head_data_s |
                     (fifo_rdata[i*DATA_W +: DATA_W] & {DATA_W{idx_q == IDX_W'(i)}});
      head_empty_s = head_empty_s & (fifo_empty[i] | (idx_q != IDX_W'(i)));
    end
  end

  assign hdr_len_s      = head_data_s[LEN_W-1:0];
  assign draining_s     = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign pop_s          = draining_s && !head_empty_s && (!valid_q || out_ready);
  assign sel_valid_s    = fifo_sel_res_final[7];
  assign sel_in_range_s = fifo_sel_res_final[6:0] < 7'(PORT_NUM);

  // One-hot pop strobe towards the locked FIFO only.
  always_comb begin
    fifo_rd_en = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      fifo_rd_en[i] = pop_s && (idx_q == IDX_W'(i));
    end
  end

  // Next-state for the drain FSM and the output register.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    err_d    = 1'b0;
`ifdef FIFO_DRAIN_WDOG_EN
    wd_d     = wd_q;
`endif

    if (pop_s) begin
      data_d  = head_data_s;
      valid_d = 1'b1;
      sop_d   = (state_q == ST_HDR);
      eop_d   = (state_q == ST_HDR) ? (hdr_len_s == '0) : (remain_q == LEN_W'(1));
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_valid_s && sel_in_range_s) begin
          idx_d   = fifo_sel_res_final[IDX_W-1:0];
          state_d = ST_HDR;
        end else if (sel_valid_s) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (pop_s) begin
          remain_d = hdr_len_s;
          state_d  = (hdr_len_s == '0) ? ST_DONE : ST_DATA;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (pop_s) begin
          remain_d = remain_q - LEN_W'(1);
          state_d  = (remain_q == LEN_W'(1)) ? ST_DONE : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef FIFO_DRAIN_WDOG_EN
    // Abort overrides the FSM; a pending output word is left untouched.
    if (!draining_s || pop_s) begin
      wd_d = '0;
    end else if (!head_empty_s) begin
      wd_d = wd_q;
    end else if (wd_q == WD_W'(WDOG_LIMIT - 1)) begin
      wd_d    = '0;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FIFO_DRAIN_WDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef FIFO_DRAIN_WDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign drain_busy = busy_q;
  assign pkt_done   = done_q;
  assign drain_err  = err_q;

endmodule

// File: tb/tb_fifo_sel_drain.sv
// Bench for fifo_sel_drain: cycle table, corner-case sequences and randomized packets
// scored against a packet-level model. Watchdog sequence runs when FIFO_DRAIN_WDOG_EN is set.
`timescale 1ns/1ps
module tb_fifo_sel_drain;
  localparam int PN = 6;
  localparam int DW = 32;
  localparam int LW = 8;
`ifdef FIFO_DRAIN_WDOG_EN
  localparam int WL = 4;
`else
  localparam int WL = 1023;
`endif

  logic              glb_clk = 1'b0;
  logic              glb_areset;
  logic [7:0]        fifo_sel_res_final;
  logic [PN-1:0]     fifo_empty;
  logic [PN*DW-1:0]  fifo_rdata;
  logic [PN-1:0]     fifo_rd_en;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              drain_busy;
  logic              pkt_done;
  logic              drain_err;

  fifo_sel_drain #(.PORT_NUM(PN), .DATA_W(DW), .LEN_W(LW), .WDOG_LIMIT(WL)) dut (
    .glb_clk(glb_clk), .glb_areset(glb_areset), .fifo_sel_res_final(fifo_sel_res_final),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
    .out_eop(out_eop), .drain_busy(drain_busy), .pkt_done(pkt_done), .drain_err(drain_err)
  );

  always #5 glb_clk = ~glb_clk;

  typedef struct {
    logic [7:0]    sel;
    logic          ready;
    logic [PN-1:0] rd_en;
    logic          valid;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          done;
    logic          busy;
    logic          err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  vec_t          vecs[12];
  logic [DW-1:0] fq[PN][$];
  logic [DW-1:0] pend[$];
  beat_t         exp_q[$];
  int            feed_p;
  bit            feed_rand;
  bit            skip_prev;
  logic [PN-1:0] rd_s;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < PN; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_rdata[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : (32'hDEAD_0000 | 32'(i));
    end
  endtask

  // Let one clock pass: pop what the DUT strobed, feed pending words, then go to negedge.
  task automatic step();
    #1;
    rd_s = fifo_rd_en;
    @(posedge glb_clk);
    #1;
    for (int i = 0; i < PN; i++) begin
      if (rd_s[i] && fq[i].size() > 0) fq[i].delete(0);
    end
    if (pend.size() > 0) begin
      if (!feed_rand) begin
        while (pend.size() > 0) fq[feed_p].push_back(pend.pop_front());
      end else if (skip_prev || $urandom_range(0, 1) == 1) begin
        fq[feed_p].push_back(pend.pop_front());
        skip_prev = 1'b0;
      end else begin
        skip_prev = 1'b1;
      end
    end
    refresh();
    @(negedge glb_clk);
  endtask

  task automatic load_pkt(input int p, input int len, input logic [DW-1:0] hdr_hi, input bit preload);
    logic [DW-1:0] w;
    w = {hdr_hi[DW-1:LW], LW'(len)};
    exp_q.push_back('{w, 1'b1, (len == 0)});
    if (preload) fq[p].push_back(w); else pend.push_back(w);
    for (int k = 0; k < len; k++) begin
      w = $urandom;
      exp_q.push_back('{w, 1'b0, (k == len - 1)});
      if (preload) fq[p].push_back(w); else pend.push_back(w);
    end
    feed_p = p;
    refresh();
  endtask

  // Start a drain of port p and score every accepted word against exp_q.
  task automatic drain_packet(input int p, input int rmode);
    int            cyc;
    int            done_cnt;
    bit            done_seen;
    bit            prev_stall;
    logic [DW+1:0] prev_v;
    logic [PN-1:0] legal;
    beat_t         b;
    cyc = 0; done_cnt = 0; done_seen = 1'b0; prev_stall = 1'b0; prev_v = '0;
    while (!(done_seen && exp_q.size() == 0 && !out_valid) && cyc < 300) begin
      if (cyc == 0) fifo_sel_res_final = 8'h80 | 8'(p);
      else if (drain_busy && !pkt_done) fifo_sel_res_final = 8'($urandom);
      else fifo_sel_res_final = 8'h00;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      #1;
      legal = (out_valid && !out_ready) ? '0 : (PN'(1) << p);
      chk("rd_en_legal", fifo_rd_en & ~legal, 0);
      chk("no_err", drain_err, 0);
      if (prev_stall) chk("stall_stable", {out_data, out_sop, out_eop}, prev_v);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("word", {out_data, out_sop, out_eop}, {b.data, b.sop, b.eop});
        end
      end
      if (pkt_done) begin
        done_cnt++;
        done_seen = 1'b1;
        chk("done_all_popped", fq[p].size() + pend.size(), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_v = {out_data, out_sop, out_eop};
      step();
      cyc++;
    end
    chk("drain_finished", (cyc < 300), 1);
    chk("pkt_done_count", done_cnt, 1);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_fail = 0; feed_rand = 1'b0; skip_prev = 1'b0; feed_p = 0;
    glb_areset = 1'b1; fifo_sel_res_final = 8'h00; out_ready = 1'b0;
    refresh();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sop_eop", {out_sop, out_eop}, 0);
    chk("rst_busy_done_err", {drain_busy, pkt_done, drain_err}, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    repeat (2) @(negedge glb_clk);
    glb_areset = 1'b0;

    // Packet {3,A,B,C} from FIFO 2, then invalid index 7 held for three cycles.
    fq[2].push_back(32'h0000_0003); fq[2].push_back(32'hA5A5_000A);
    fq[2].push_back(32'hA5A5_000B); fq[2].push_back(32'hA5A5_000C);
    refresh();
    vecs[0]  = '{8'h82, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 1'b1, 6'b000100, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 6'b000100, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h00, 1'b1, 6'b000100, 1'b1, 32'hA5A5_000A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h00, 1'b1, 6'b000100, 1'b1, 32'hA5A5_000B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 6'b000000, 1'b1, 32'hA5A5_000C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h00, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h87, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h87, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'h87, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h00, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h00, 1'b1, 6'b000000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int r = 0; r < 12; r++) begin
      fifo_sel_res_final = vecs[r].sel;
      out_ready = vecs[r].ready;
      #1;
      chk($sformatf("vec%0d_rd_en", r), fifo_rd_en, vecs[r].rd_en);
      chk($sformatf("vec%0d_valid", r), out_valid, vecs[r].valid);
      chk($sformatf("vec%0d_busy", r), drain_busy, vecs[r].busy);
      chk($sformatf("vec%0d_done", r), pkt_done, vecs[r].done);
      chk($sformatf("vec%0d_err", r), drain_err, vecs[r].err);
      if (vecs[r].valid) begin
        chk($sformatf("vec%0d_data", r), out_data, vecs[r].data);
        chk($sformatf("vec%0d_sop_eop", r), {out_sop, out_eop}, {vecs[r].sop, vecs[r].eop});
      end
      step();
    end

    // Zero-length packet from FIFO 0: one word with sop and eop, done right after.
    fq[0].push_back(32'h0000_0000);
    refresh();
    fifo_sel_res_final = 8'h80; out_ready = 1'b1;
    step();
    fifo_sel_res_final = 8'h00;
    #1;
    chk("zl_rd_en", fifo_rd_en, 6'b000001);
    step();
    #1;
    chk("zl_word", {out_valid, out_data, out_sop, out_eop}, {1'b1, 32'h0, 1'b1, 1'b1});
    chk("zl_done", {pkt_done, drain_busy}, 2'b11);
    step();
    #1;
    chk("zl_idle", {pkt_done, drain_busy, out_valid}, 3'b000);

    // Backpressure with ready pattern 1,0,0,1.
    load_pkt(2, 3, 32'h0, 1'b1);
    drain_packet(2, 1);

    // Reset after the second pop of a 5-word packet on FIFO 4.
    load_pkt(4, 4, $urandom, 1'b1);
    fifo_sel_res_final = 8'h84; out_ready = 1'b1;
    step();
    fifo_sel_res_final = 8'h00;
    step();
    step();
    #1;
    chk("pre_rst_valid_busy", {out_valid, drain_busy}, 2'b11);
    #2;
    glb_areset = 1'b1;
    #1;
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_valid_sop_eop", {out_valid, out_sop, out_eop}, 0);
    chk("mid_rst_busy_done_err", {drain_busy, pkt_done, drain_err}, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    @(negedge glb_clk);
    glb_areset = 1'b0;
    fq[4].delete();
    exp_q.delete();
    refresh();
    load_pkt(1, 2, $urandom, 1'b1);
    drain_packet(1, 0);

`ifdef FIFO_DRAIN_WDOG_EN
    // Empty FIFO 3 trips the watchdog four cycles into HDR.
    fifo_sel_res_final = 8'h83; out_ready = 1'b1;
    step();
    fifo_sel_res_final = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("wd_wait%0d", c), {drain_busy, drain_err, pkt_done, fifo_rd_en}, {3'b100, 6'b0});
      step();
    end
    #1;
    chk("wd_abort", {drain_busy, drain_err, pkt_done}, 3'b010);
    step();
    #1;
    chk("wd_after", {drain_busy, drain_err, pkt_done}, 3'b000);
`else
    // Without the watchdog an empty FIFO simply holds the block in HDR.
    fifo_sel_res_final = 8'h83; out_ready = 1'b1;
    step();
    fifo_sel_res_final = 8'h00;
    for (int c = 0; c < 20; c++) step();
    #1;
    chk("nowd_waiting", {drain_busy, drain_err, pkt_done}, 3'b100);
    load_pkt(3, 0, 32'h0, 1'b1);
    drain_packet(3, 0);
`endif

    // Randomized packets with random ready, feeding gaps and header upper bits.
    feed_rand = 1'b1;
    for (int n = 0; n < 16; n++) begin
      int p;
      p = $urandom_range(0, PN - 1);
      skip_prev = 1'b0;
      load_pkt(p, $urandom_range(0, 7), $urandom, 1'($urandom_range(0, 1)));
      drain_packet(p, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
